// File: rtl/fetch_stage_m1_if.sv
// Fetch-stage bus bundle: instruction-memory request/response channel and decode-side head.
interface fetch_stage_m1_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [14:0] imem_addr;
  logic        imem_rsp_valid;
  logic [15:0] imem_rsp_data;
  logic        hazard_stall;
  logic        inst_valid;
  logic [15:0] instruction_out;
  logic [14:0] pc_out;

  modport master (
    output imem_req_valid, imem_addr, inst_valid, instruction_out, pc_out,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, hazard_stall
  );

  modport slave (
    input  imem_req_valid, imem_addr, inst_valid, instruction_out, pc_out,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, hazard_stall
  );
endinterface

// File: rtl/fetch_stage_m1.sv
// M1 instruction fetch front end: credit-limited imem requests, in-order response
// buffering with PCs, decode back-pressure and flush with squashed-response dropping.
module fetch_stage_m1 #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [14:0] RESET_PC   = 15'h0000
) (
  input  logic             clk,
  input  logic             sync_rst_n,
  input  logic             clk_en,
  input  logic             flush,
  input  logic [14:0]      redirect_pc,
  fetch_stage_m1_if.master bus
);
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned SUM_W  = CNT_W + 1;
  localparam int unsigned PC_W   = 15;
  localparam int unsigned WORD_W = 16;

  logic [PC_W-1:0]   fetch_pc_q;
  logic [CNT_W-1:0]  outstanding_q;
  logic [CNT_W-1:0]  drop_cnt_q;
  logic [CNT_W-1:0]  ib_wr_q, ib_rd_q;
  logic [CNT_W-1:0]  rq_wr_q, rq_rd_q;
  logic [WORD_W-1:0] ib_word [FIFO_DEPTH];
  logic [PC_W-1:0]   ib_pc   [FIFO_DEPTH];
  logic [PC_W-1:0]   rq_pc   [FIFO_DEPTH];

  logic [CNT_W-1:0]  ib_count_c;
  logic              ib_empty_c;
  logic              ib_full_c;
  logic              credit_ok_c;
  logic              req_valid_c;
  logic              accept_c;
  logic              rsp_c;
  logic              push_c;
  logic              pop_c;

  // Credit: buffered words plus in-flight requests never exceed buffer depth.
  always_comb begin
    ib_count_c  = ib_wr_q - ib_rd_q;
    ib_empty_c  = (ib_count_c == '0);
    ib_full_c   = (ib_count_c == CNT_W'(FIFO_DEPTH));
    credit_ok_c = (SUM_W'(outstanding_q) + SUM_W'(ib_count_c)) < SUM_W'(FIFO_DEPTH);
    req_valid_c = clk_en & ~flush & credit_ok_c;
    accept_c    = req_valid_c & bus.imem_req_ready;
    rsp_c       = clk_en & bus.imem_rsp_valid;
    push_c      = rsp_c & ~flush & (drop_cnt_q == '0);
    pop_c       = clk_en & ~ib_empty_c & ~bus.hazard_stall & ~flush;
  end

  assign bus.imem_req_valid  = req_valid_c;
  assign bus.imem_addr       = fetch_pc_q;
  assign bus.inst_valid      = ~ib_empty_c;
  assign bus.instruction_out = ib_empty_c ? '0 : ib_word[ib_rd_q[PTR_W-1:0]];
  assign bus.pc_out          = ib_empty_c ? '0 : ib_pc[ib_rd_q[PTR_W-1:0]];

  // Control state; a flush leaves all in-flight requests to be dropped on return.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      ib_wr_q       <= '0;
      ib_rd_q       <= '0;
      rq_wr_q       <= '0;
      rq_rd_q       <= '0;
    end else if (clk_en) begin
      outstanding_q <= outstanding_q + CNT_W'(accept_c) - CNT_W'(rsp_c);
      if (accept_c) rq_wr_q <= rq_wr_q + CNT_W'(1);
      if (rsp_c)    rq_rd_q <= rq_rd_q + CNT_W'(1);
      if (flush) begin
        fetch_pc_q <= redirect_pc;
        ib_wr_q    <= '0;
        ib_rd_q    <= '0;
        drop_cnt_q <= outstanding_q - CNT_W'(rsp_c);
      end else begin
        if (accept_c) fetch_pc_q <= fetch_pc_q + PC_W'(1);
        if (push_c)   ib_wr_q    <= ib_wr_q + CNT_W'(1);
        if (pop_c)    ib_rd_q    <= ib_rd_q + CNT_W'(1);
        if (rsp_c && (drop_cnt_q != '0)) drop_cnt_q <= drop_cnt_q - CNT_W'(1);
      end
    end
  end

  // Storage arrays; contents are qualified by the pointers so need no reset.
  always_ff @(posedge clk) begin
    if (sync_rst_n && clk_en) begin
      if (accept_c) rq_pc[rq_wr_q[PTR_W-1:0]] <= fetch_pc_q;
      if (push_c) begin
        ib_word[ib_wr_q[PTR_W-1:0]] <= bus.imem_rsp_data;
        ib_pc[ib_wr_q[PTR_W-1:0]]   <= rq_pc[rq_rd_q[PTR_W-1:0]];
      end
    end
  end

  ib_no_overflow_a: assert property (@(posedge clk) disable iff (!sync_rst_n) !(push_c && ib_full_c));

endmodule

// File: tb/tb_fetch_stage_m1.sv
// Randomized self-checking bench for fetch_stage_m1 against a queue-based fetch model.
module tb_fetch_stage_m1;
  logic        clk = 1'b0;
  logic        sync_rst_n;
  logic        clk_en;
  logic        flush;
  logic [14:0] redirect_pc;

  fetch_stage_m1_if bus();

  fetch_stage_m1 #(.FIFO_DEPTH(4), .RESET_PC(15'h0000)) dut (
    .clk         (clk),
    .sync_rst_n  (sync_rst_n),
    .clk_en      (clk_en),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    int          due;
    bit          squashed;
  } req_t;

  typedef struct {
    logic [15:0] word;
    logic [14:0] pc;
  } ent_t;

  req_t        inflight[$];
  ent_t        ibuf[$];
  logic [14:0] m_pc;
  int          cyc = 0;
  int          last_due = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          n_checks = 0;
  int          n_pass = 0;
  int          dut_acc = 0;

  function automatic logic [15:0] mem_word(input logic [14:0] a);
    return {1'b0, a} ^ 16'hA5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic do_reset();
    sync_rst_n           = 1'b0;
    clk_en               = 1'b0;
    flush                = 1'b0;
    redirect_pc          = 15'h0;
    bus.hazard_stall     = 1'b0;
    bus.imem_req_ready   = 1'b0;
    bus.imem_rsp_valid   = 1'b0;
    bus.imem_rsp_data    = 16'h0;
    @(posedge clk);
    #1;
    sync_rst_n = 1'b1;
    inflight.delete();
    ibuf.delete();
    m_pc     = 15'h0000;
    last_due = cyc;
    cyc++;
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model.
  task automatic step(input bit en, input bit st, input bit fl, input logic [14:0] rpc, input bit rdy);
    bit          rsp, exp_rv, acc, pop;
    req_t        r;
    ent_t        e;
    int          lat;
    logic [15:0] exp_word;
    logic [14:0] exp_pc;
    clk_en             = en;
    bus.hazard_stall   = st;
    flush              = fl;
    redirect_pc        = rpc;
    bus.imem_req_ready = rdy;
    rsp = en && (inflight.size() > 0) && (inflight[0].due <= cyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(inflight[0].addr) : 16'($urandom);
    #1;
    exp_rv   = en && !fl && ((inflight.size() + ibuf.size()) < 4);
    exp_word = 16'h0;
    exp_pc   = 15'h0;
    if (ibuf.size() > 0) begin
      exp_word = ibuf[0].word;
      exp_pc   = ibuf[0].pc;
    end
    check("imem_req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
    if (exp_rv) check("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
    check("inst_valid", 32'(bus.inst_valid), 32'(ibuf.size() > 0));
    check("instruction_out", 32'(bus.instruction_out), 32'(exp_word));
    check("pc_out", 32'(bus.pc_out), 32'(exp_pc));
    if (bus.imem_req_valid === 1'b1 && rdy) dut_acc++;
    acc = exp_rv && rdy;
    if (en) begin
      pop = (ibuf.size() > 0) && !st && !fl;
      if (pop) void'(ibuf.pop_front());
      if (rsp) begin
        r = inflight.pop_front();
        if (!fl && !r.squashed) begin
          e.word = mem_word(r.addr);
          e.pc   = r.addr;
          ibuf.push_back(e);
        end
      end
      if (fl) begin
        foreach (inflight[i]) inflight[i].squashed = 1'b1;
        ibuf.delete();
        m_pc = rpc;
      end else if (acc) begin
        lat        = $urandom_range(lat_max, lat_min);
        r.addr     = m_pc;
        r.due      = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
        r.squashed = 1'b0;
        last_due   = r.due;
        inflight.push_back(r);
        m_pc = m_pc + 15'd1;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    do_reset();
    // Reset state, then streaming with a one-cycle memory
    step(1'b0, 1'b0, 1'b0, 15'h0, 1'b1);
    repeat (12) step(1'b1, 1'b0, 1'b0, 15'h0, 1'b1);

    // Decode stall from a fresh start: credit caps requests at four
    do_reset();
    dut_acc = 0;
    repeat (10) step(1'b1, 1'b1, 1'b0, 15'h0, 1'b1);
    check("stall_req_count", 32'(dut_acc), 32'd4);
    repeat (8) step(1'b1, 1'b0, 1'b0, 15'h0, 1'b1);

    // Flush with responses still in flight
    lat_min = 3; lat_max = 3;
    repeat (3) step(1'b1, 1'b0, 1'b0, 15'h0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 15'h0100, 1'b1);
    lat_min = 1; lat_max = 1;
    repeat (8) step(1'b1, 1'b0, 1'b0, 15'h0, 1'b1);

    // Flush coinciding with a response and a stall
    lat_min = 2; lat_max = 2;
    repeat (4) step(1'b1, 1'b0, 1'b0, 15'h0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 15'h0200, 1'b1);
    repeat (8) step(1'b1, 1'b0, 1'b0, 15'h0, 1'b1);

    // PC wrap
    lat_min = 1; lat_max = 1;
    step(1'b1, 1'b0, 1'b1, 15'h7FFE, 1'b1);
    repeat (10) step(1'b1, 1'b0, 1'b0, 15'h0, 1'b1);

    // Mid-stream reset with the clock enable low
    repeat (3) step(1'b1, 1'b0, 1'b0, 15'h0, 1'b1);
    do_reset();
    step(1'b0, 1'b0, 1'b0, 15'h0, 1'b1);
    repeat (6) step(1'b1, 1'b0, 1'b0, 15'h0, 1'b1);

    // Randomized traffic
    lat_min = 1; lat_max = 3;
    repeat (3000) begin
      logic [14:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? 15'(15'h7FFC + 15'($urandom_range(0, 3))) : 15'($urandom);
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 19) == 0, rpc, $urandom_range(0, 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
